// File: rtl/env_access_ctrl.sv
//==============================================================================
// env_access_ctrl : arbitrates ant lookup/deposit and render reads onto a grid
// of cells via one-hot select strobes. Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module env_access_ctrl #(
  parameter int N      = 17,
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  localparam int CELLS = GRID_W * GRID_H,
  localparam int XW    = $clog2(GRID_W) + 1,
  localparam int YW    = $clog2(GRID_H) + 1,
  localparam int AW    = $clog2(CELLS) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Ant_Req,
  input  logic             Ant_Op,
  input  logic [XW-1:0]    Ant_X,
  input  logic [YW-1:0]    Ant_Y,
  input  logic [N-2:0]     Ant_Amt,
  output logic             Ant_Ack,
  output logic             Ant_Err,
  output logic [N-1:0]     Ant_Data,
  input  logic             Render_Req,
  input  logic [AW-1:0]    Render_Addr,
  output logic             Render_Valid,
  output logic [N-1:0]     Render_Data,
  output logic [CELLS-1:0] Lookup_Sel,
  output logic [CELLS-1:0] Render_Sel,
  output logic [CELLS-1:0] Ld_Sel,
  output logic [N-1:0]     Cell_Wr_Data,
  input  logic [N-1:0]     Cell_Rd_Data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RENDER = 3'd1,
    S_READ   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           op_q, op_d;
  logic           oor_q, oor_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [N-2:0]   amt_q, amt_d;
  logic [N-1:0]   ant_data_q, ant_data_d;
  logic [N-1:0]   render_data_q, render_data_d;
  logic           render_valid_q, render_valid_d;

  logic [AW-1:0]    w_ant_lin;
  logic             w_ant_oor;
  logic             w_render_oor;
  logic [CELLS-1:0] w_onehot;
  logic [N-1:0]     w_sum;
  logic [N-2:0]     w_sat;

  assign w_ant_lin    = AW'(Ant_Y) * AW'(GRID_W) + AW'(Ant_X);
  assign w_ant_oor    = (Ant_X >= XW'(GRID_W)) || (Ant_Y >= YW'(GRID_H));
  assign w_render_oor = (Render_Addr >= AW'(CELLS));
  assign w_onehot     = {{(CELLS-1){1'b0}}, 1'b1} << idx_q;

  // Deposit adds to the signal field only; carry-out means clamp to all-ones.
  assign w_sum = {1'b0, ant_data_q[N-2:0]} + {1'b0, amt_q};
  assign w_sat = w_sum[N-1] ? {(N-1){1'b1}} : w_sum[N-2:0];

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    oor_d          = oor_q;
    idx_d          = idx_q;
    amt_d          = amt_q;
    ant_data_d     = ant_data_q;
    render_data_d  = render_data_q;
    render_valid_d = 1'b0;
    Lookup_Sel     = '0;
    Render_Sel     = '0;
    Ld_Sel         = '0;
    Cell_Wr_Data   = '0;

    case (state_q)
      S_IDLE: begin
        // A render request still held during its own valid pulse is not re-accepted.
        if (Render_Req && !render_valid_q) begin
          state_d = S_RENDER;
          idx_d   = Render_Addr;
          oor_d   = w_render_oor;
        end else if (Ant_Req) begin
          state_d = S_READ;
          op_d    = Ant_Op;
          amt_d   = Ant_Amt;
          idx_d   = w_ant_lin;
          oor_d   = w_ant_oor;
        end
      end
      S_RENDER: begin
        if (!oor_q) Render_Sel = w_onehot;
        render_data_d  = oor_q ? '0 : Cell_Rd_Data;
        render_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      S_READ: begin
        if (!oor_q) Lookup_Sel = w_onehot;
        ant_data_d = oor_q ? '0 : Cell_Rd_Data;
        state_d    = op_q ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        if (!oor_q) begin
          Ld_Sel       = w_onehot;
          Cell_Wr_Data = {ant_data_q[N-1], w_sat};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      op_q           <= 1'b0;
      oor_q          <= 1'b0;
      idx_q          <= '0;
      amt_q          <= '0;
      ant_data_q     <= '0;
      render_data_q  <= '0;
      render_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      oor_q          <= oor_d;
      idx_q          <= idx_d;
      amt_q          <= amt_d;
      ant_data_q     <= ant_data_d;
      render_data_q  <= render_data_d;
      render_valid_q <= render_valid_d;
    end
  end

  assign Ant_Ack      = (state_q == S_DONE);
  assign Ant_Err      = (state_q == S_DONE) && oor_q;
  assign Ant_Data     = ant_data_q;
  assign Render_Valid = render_valid_q;
  assign Render_Data  = render_data_q;

endmodule

`default_nettype wire

// File: tb/tb_env_access_ctrl.sv
//==============================================================================
// tb_env_access_ctrl : directed + random transactions against a cell-grid model.
// Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_env_access_ctrl;

  localparam int N     = 17;
  localparam int GW    = 8;
  localparam int GH    = 8;
  localparam int CELLS = GW * GH;
  localparam int XW    = 4;
  localparam int YW    = 4;
  localparam int AW    = 7;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Ant_Req, Ant_Op;
  logic [XW-1:0]    Ant_X;
  logic [YW-1:0]    Ant_Y;
  logic [N-2:0]     Ant_Amt;
  logic             Ant_Ack, Ant_Err;
  logic [N-1:0]     Ant_Data;
  logic             Render_Req;
  logic [AW-1:0]    Render_Addr;
  logic             Render_Valid;
  logic [N-1:0]     Render_Data;
  logic [CELLS-1:0] Lookup_Sel, Render_Sel, Ld_Sel;
  logic [N-1:0]     Cell_Wr_Data, Cell_Rd_Data;

  logic [N-1:0] mem     [CELLS];
  logic [N-1:0] ref_mem [CELLS];

  int n_cmp = 0;
  int n_err = 0;

  env_access_ctrl #(.N(N), .GRID_W(GW), .GRID_H(GH)) dut (
    .Clk(Clk), .Reset(Reset),
    .Ant_Req(Ant_Req), .Ant_Op(Ant_Op), .Ant_X(Ant_X), .Ant_Y(Ant_Y), .Ant_Amt(Ant_Amt),
    .Ant_Ack(Ant_Ack), .Ant_Err(Ant_Err), .Ant_Data(Ant_Data),
    .Render_Req(Render_Req), .Render_Addr(Render_Addr),
    .Render_Valid(Render_Valid), .Render_Data(Render_Data),
    .Lookup_Sel(Lookup_Sel), .Render_Sel(Render_Sel), .Ld_Sel(Ld_Sel),
    .Cell_Wr_Data(Cell_Wr_Data), .Cell_Rd_Data(Cell_Rd_Data)
  );

  always #5 Clk = ~Clk;

  // Cell grid environment: OR-combined read bus, load on strobe.
  always_comb begin
    Cell_Rd_Data = '0;
    for (int i = 0; i < CELLS; i++)
      if (Lookup_Sel[i] || Render_Sel[i]) Cell_Rd_Data = Cell_Rd_Data | mem[i];
  end

  always @(posedge Clk) begin
    for (int i = 0; i < CELLS; i++)
      if (Ld_Sel[i]) mem[i] = Cell_Wr_Data;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe exclusivity and idle write bus, every cycle out of reset.
  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      int nz;
      logic ok;
      nz = int'(Lookup_Sel != 0) + int'(Render_Sel != 0) + int'(Ld_Sel != 0);
      ok = (nz <= 1) && $onehot0(Lookup_Sel) && $onehot0(Render_Sel) && $onehot0(Ld_Sel)
           && ((Ld_Sel != 0) || (Cell_Wr_Data == 0));
      check("sel_rules", {127'd0, ok}, 128'd1);
    end
  end

  task automatic ant_txn(input logic op, input int x, input int y, input logic [15:0] amt);
    logic        oor;
    int          idx, s, cyc;
    logic [16:0] exp_data, exp_wr;
    logic [63:0] exp_sel;
    oor      = (x >= GW) || (y >= GH);
    idx      = y * GW + x;
    exp_data = oor ? 17'd0 : ref_mem[idx];
    s        = int'(exp_data[15:0]) + int'(amt);
    if (s > 65535) s = 65535;
    exp_wr   = {exp_data[16], s[15:0]};
    exp_sel  = oor ? 64'd0 : (64'd1 << idx);
    if (!oor && op) ref_mem[idx] = exp_wr;

    @(posedge Clk); #1;
    Ant_Req = 1'b1; Ant_Op = op; Ant_X = x[3:0]; Ant_Y = y[3:0]; Ant_Amt = amt;
    cyc = 0;
    while (cyc < 8) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 1) check("lookup_sel", 128'(Lookup_Sel), 128'(exp_sel));
      if (op && cyc == 2) begin
        check("ld_sel", 128'(Ld_Sel), 128'(exp_sel));
        if (!oor) check("wr_data", 128'(Cell_Wr_Data), 128'(exp_wr));
      end
      if (Ant_Ack) break;
    end
    check("ant_latency", 128'(cyc), op ? 128'd3 : 128'd2);
    check("ant_data", 128'(Ant_Data), 128'(exp_data));
    check("ant_err", 128'(Ant_Err), 128'(oor));
    Ant_Req = 1'b0;
  endtask

  task automatic render_txn(input int addr);
    logic [16:0] exp_data;
    logic [63:0] exp_sel;
    int          cyc;
    exp_data = (addr >= CELLS) ? 17'd0 : ref_mem[addr];
    exp_sel  = (addr >= CELLS) ? 64'd0 : (64'd1 << addr);
    @(posedge Clk); #1;
    Render_Req = 1'b1; Render_Addr = addr[6:0];
    cyc = 0;
    while (cyc < 8) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 1) check("render_sel", 128'(Render_Sel), 128'(exp_sel));
      if (Render_Valid) break;
    end
    check("render_latency", 128'(cyc), 128'd2);
    check("render_data", 128'(Render_Data), 128'(exp_data));
    Render_Req = 1'b0;
  endtask

  initial begin
    int rv_cyc, ack_cyc, cyc;
    Reset = 1'b1; Ant_Req = 1'b0; Ant_Op = 1'b0; Ant_X = '0; Ant_Y = '0; Ant_Amt = '0;
    Render_Req = 1'b0; Render_Addr = '0;
    for (int i = 0; i < CELLS; i++) begin
      mem[i]     = 17'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[10] = 17'h00005; ref_mem[10] = 17'h00005;
    mem[35] = 17'h10020; ref_mem[35] = 17'h10020;
    mem[20] = 17'h00777; ref_mem[20] = 17'h00777;

    repeat (3) @(posedge Clk);
    #1;
    check("rst_ack",   128'(Ant_Ack), 128'd0);
    check("rst_err",   128'(Ant_Err), 128'd0);
    check("rst_rvld",  128'(Render_Valid), 128'd0);
    check("rst_adata", 128'(Ant_Data), 128'd0);
    check("rst_rdata", 128'(Render_Data), 128'd0);
    check("rst_sels",  128'(Lookup_Sel | Render_Sel | Ld_Sel), 128'd0);
    Reset = 1'b0;

    ant_txn(1'b0, 2, 1, 16'h0000);       // cell 10 lookup
    ant_txn(1'b1, 3, 4, 16'hFFF0);       // cell 35 saturating deposit
    ant_txn(1'b0, 3, 4, 16'h0000);
    ant_txn(1'b1, 8, 0, 16'h1234);       // column out of range
    ant_txn(1'b0, 0, 8, 16'h0000);       // row out of range
    ant_txn(1'b1, 15, 15, 16'h0001);
    render_txn(10);
    render_txn(64);
    render_txn(127);

    // Render and ant requests raised together: render wins.
    @(posedge Clk); #1;
    Render_Req = 1'b1; Render_Addr = 7'd35;
    Ant_Req = 1'b1; Ant_Op = 1'b0; Ant_X = 4'd2; Ant_Y = 4'd1;
    rv_cyc = 0; ack_cyc = 0; cyc = 0;
    while (cyc < 10) begin
      @(posedge Clk); #1;
      cyc++;
      if (Render_Valid && rv_cyc == 0) begin
        rv_cyc = cyc;
        check("both_rdata", 128'(Render_Data), 128'(ref_mem[35]));
        Render_Req = 1'b0;
      end
      if (Ant_Ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    check("both_rv_cyc",  128'(rv_cyc), 128'd2);
    check("both_ack_cyc", 128'(ack_cyc), 128'd4);
    check("both_adata",   128'(Ant_Data), 128'(ref_mem[10]));
    Ant_Req = 1'b0; Render_Req = 1'b0;

    // Reset while a deposit sits in READ: the write must never happen.
    @(posedge Clk); #1;
    Ant_Req = 1'b1; Ant_Op = 1'b1; Ant_X = 4'd4; Ant_Y = 4'd2; Ant_Amt = 16'h0100;
    @(posedge Clk); #1;
    check("rstmid_lookup", 128'(Lookup_Sel), 128'(64'd1 << 20));
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("rstmid_ack",   128'(Ant_Ack), 128'd0);
    check("rstmid_err",   128'(Ant_Err), 128'd0);
    check("rstmid_adata", 128'(Ant_Data), 128'd0);
    check("rstmid_rdata", 128'(Render_Data), 128'd0);
    check("rstmid_rvld",  128'(Render_Valid), 128'd0);
    check("rstmid_sels",  128'(Lookup_Sel | Render_Sel | Ld_Sel), 128'd0);
    check("rstmid_wr",    128'(Cell_Wr_Data), 128'd0);
    Reset = 1'b0; Ant_Req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      check("post_rst_ld",  128'(Ld_Sel), 128'd0);
      check("post_rst_ack", 128'(Ant_Ack), 128'd0);
    end

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        render_txn(int'($urandom_range(0, 70)));
      end else begin
        int x, y;
        x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
        y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
        ant_txn(1'($urandom_range(0, 1)), x, y, 16'($urandom));
      end
    end

    @(posedge Clk); #1;
    for (int i = 0; i < CELLS; i++)
      check($sformatf("cell_%0d", i), 128'(mem[i]), 128'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
